result_trace_fifo: RTL and testbench
====================================

# result_trace_fifo

Downstream capture stage for the RISCCPU `result` bus. Samples the 16-bit result when the CPU flags it valid and optionally drops repeats of the previous sample. Buffers accepted values in a first-word-fall-through FIFO and presents them on a valid/ready port to a debug or host consumer. Counts values dropped because the FIFO was full.

## Interface
- DATA_WIDTH, 16, width of result and FIFO entries
- DEPTH, 8, FIFO entries; power of two, 2..256
- CHANGE_ONLY, 1, 1 = capture only when the sample differs from the previous valid sample; 0 = capture every valid sample
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- result_in  input  DATA_WIDTH  result bus from RISCCPU
- result_valid  input  1  result_in is meaningful this cycle
- out_data  output  DATA_WIDTH  FIFO head; valid only while out_valid=1
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- count  output  clog2(DEPTH)+1  entries currently stored
- full  output  1  count == DEPTH
- overflow_cnt  output  8  dropped samples, saturating at 255

## Operation
- Qualify: sample = result_valid && (CHANGE_ONLY==0 || !have_last || result_in != last_val).
- On every cycle with result_valid=1: last_val <= result_in, have_last <= 1, whether or not the sample is pushed or dropped.
- pop = out_valid && out_ready.
- push = sample && (!full || pop). With a pop in the same cycle, a push into a full FIFO is legal.
- drop = sample && full && !pop. On drop, overflow_cnt increments by 1 unless it is already 255. The FIFO is unchanged.
- Storage: DEPTH x DATA_WIDTH register array with write and read pointers of clog2(DEPTH) bits. Both pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_data = mem[rd_ptr], driven combinationally from the registered array. It holds stable while out_valid=1 and out_ready=0.
- Pop on an empty FIFO cannot occur, because out_valid=0 when empty.
- Reset, asserted at any time including mid-burst:
  - pointers, count, last_val, have_last and overflow_cnt cleared;
  - out_valid=0, full=0, count=0, overflow_cnt=0;
  - out_data value is don't-care, but it must not be X-driven from uninitialised memory (clear the array or gate the output to 0 when empty).

## Timing
- Capture latency: a sample accepted at rising edge N is visible at out_data with out_valid=1 immediately after edge N. There are no further delay stages.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Pop takes effect at the edge where out_valid && out_ready. The next entry, or out_valid=0, appears after that edge.
- full, count and out_valid are registered-state derived. They change only at clock edges or on reset assertion.
- The consumer may hold out_ready high continuously. The block places no requirement on out_ready before out_valid.
- Simultaneous push and pop on an empty FIFO (count=0): no pop occurs, because out_valid=0. The push lands and count becomes 1.

## Test plan
- Reset values:
  - Stimulus: assert reset mid-cycle with 3 entries stored and overflow_cnt=2.
  - Response: out_valid, full, count and overflow_cnt go to 0 without waiting for a clock edge.
  - After release, the first valid sample is always captured, even in CHANGE_ONLY mode.
- Basic order:
  - Stimulus: out_ready=0; push 0x0011, 0x0022, 0x0033 on consecutive cycles; then out_ready=1.
  - Response: out_data reads 0011, 0022, 0033 on three consecutive cycles. count goes 3,2,1,0, then out_valid=0.
- Change filter:
  - Stimulus: CHANGE_ONLY=1; valid sequence 0x00A5, 0x00A5, 0x00A5, 0x0100, 0x00A5.
  - Response: count=3 with contents A5, 100, A5.
  - Same stimulus with CHANGE_ONLY=0: count=5.
- Overflow:
  - Stimulus: out_ready=0; 11 distinct samples.
  - Response: full=1 after the 8th sample; overflow_cnt=3; FIFO holds samples 1-8 in order.
  - Continue with 300 more drops: overflow_cnt saturates at 255.
- Full plus simultaneous push/pop:
  - Stimulus: FIFO full with 1..8; one cycle with out_ready=1 and a new sample 0x0009.
  - Response: count stays 8, full stays 1, overflow_cnt unchanged; head becomes 2; the tail entry is 9.
- Pointer wrap: 20 samples streamed with out_ready=1 continuously, which wraps the pointers twice. All 20 values emerge in order, and count never exceeds 1.

Source files
------------

// File: rtl/result_trace_fifo_if.sv
// Capture/consume port bundle for result_trace_fifo.
// The slave modport is the FIFO's view: it takes CPU result samples and the
// consumer's ready, and it presents the head entry and the status counters.
// The master modport is the view of whatever drives the FIFO and consumes it.
interface result_trace_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] result_in;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic [7:0]            overflow_cnt;

  modport master (
    output result_in, result_valid, out_ready,
    input  out_data, out_valid, count, full, overflow_cnt
  );

  modport slave (
    input  result_in, result_valid, out_ready,
    output out_data, out_valid, count, full, overflow_cnt
  );
endinterface

// File: rtl/result_trace_fifo.sv
// result_trace_fifo: captures valid RISCCPU result samples, optionally keeping
// only values that differ from the previous valid sample. Captured values go
// into a first-word-fall-through FIFO that drains over a valid/ready port.
// Samples that arrive while the FIFO is full and not draining are dropped,
// and a saturating 8-bit counter records how many were dropped.
module result_trace_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int CHANGE_ONLY = 1
) (
  input logic                clk,
  input logic                reset,
  result_trace_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] last_val_q, last_val_d;
  logic                  have_last_q, have_last_d;
  logic [7:0]            ovf_q, ovf_d;

  logic sample_s, full_s, empty_s, pop_s, push_s, drop_s;

  // Handshake qualification, all derived from registered state and inputs.
  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty_s  = (count_q == {CNT_W{1'b0}});
    sample_s = bus.result_valid &&
               ((CHANGE_ONLY == 0) || !have_last_q || (bus.result_in != last_val_q));
    pop_s    = !empty_s && bus.out_ready;
    // A simultaneous pop frees one slot, so a full FIFO can still accept a push.
    push_s   = sample_s && (!full_s || pop_s);
    drop_s   = sample_s && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy, change filter and drop counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_val_d  = last_val_q;
    have_last_d = have_last_q;
    ovf_d       = ovf_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // The filter tracks every valid sample, including ones that are dropped.
    if (bus.result_valid) begin
      last_val_d  = bus.result_in;
      have_last_d = 1'b1;
    end else begin
      last_val_d  = last_val_q;
      have_last_d = have_last_q;
    end

    if (drop_s && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      last_val_q  <= {DATA_WIDTH{1'b0}};
      have_last_q <= 1'b0;
      ovf_q       <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_val_q  <= last_val_d;
      have_last_q <= have_last_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array; it is cleared on reset so the head never reads as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= bus.result_in;
    end
  end

  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.out_valid    = !empty_s;
  assign bus.count        = count_q;
  assign bus.full         = full_s;
  assign bus.overflow_cnt = ovf_q;
endmodule

// File: tb/tb_result_trace_fifo.sv
// Directed testbench for result_trace_fifo. One instance runs with the change
// filter on and a second runs with it off. Both see identical stimulus.
module tb_result_trace_fifo;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  result_trace_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus1 ();
  result_trace_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus0 ();

  result_trace_fifo #(.DATA_WIDTH(16), .DEPTH(8), .CHANGE_ONLY(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  result_trace_fifo #(.DATA_WIDTH(16), .DEPTH(8), .CHANGE_ONLY(0)) u_dut_all (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] v, input logic vld, input logic rdy);
    bus1.result_in = v; bus1.result_valid = vld; bus1.out_ready = rdy;
    bus0.result_in = v; bus0.result_valid = vld; bus0.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  logic [15:0] basic_v [3];
  logic [15:0] chg_v   [5];
  logic [15:0] chg_exp [3];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    basic_v = '{16'h0011, 16'h0022, 16'h0033};
    chg_v   = '{16'h00A5, 16'h00A5, 16'h00A5, 16'h0100, 16'h00A5};
    chg_exp = '{16'h00A5, 16'h0100, 16'h00A5};

    // Power-on reset
    reset = 1'b1;
    drive(16'h0000, 1'b0, 1'b0);
    repeat (2) tick();
    check("por_valid", 32'(bus1.out_valid), 32'd0);
    check("por_full",  32'(bus1.full), 32'd0);
    check("por_count", 32'(bus1.count), 32'd0);
    check("por_ovf",   32'(bus1.overflow_cnt), 32'd0);
    reset = 1'b0;

    // Basic order and capture latency
    drive(basic_v[0], 1'b1, 1'b0);
    tick();
    check("lat_valid", 32'(bus1.out_valid), 32'd1);
    check("lat_data",  32'(bus1.out_data), 32'h0011);
    check("lat_count", 32'(bus1.count), 32'd1);
    drive(basic_v[1], 1'b1, 1'b0);
    tick();
    drive(basic_v[2], 1'b1, 1'b0);
    tick();
    check("basic_count3", 32'(bus1.count), 32'd3);
    drive(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("basic_head",  32'(bus1.out_data), 32'(basic_v[i]));
      check("basic_count", 32'(bus1.count), 32'(3 - i));
      tick();
    end
    check("basic_empty_cnt",   32'(bus1.count), 32'd0);
    check("basic_empty_valid", 32'(bus1.out_valid), 32'd0);

    // Change filter against capture-all
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(chg_v[i], 1'b1, 1'b0);
      tick();
    end
    check("chg_count_on",  32'(bus1.count), 32'd3);
    check("chg_count_off", 32'(bus0.count), 32'd5);
    drive(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("chg_head", 32'(bus1.out_data), 32'(chg_exp[i]));
      tick();
    end
    check("chg_drained", 32'(bus1.out_valid), 32'd0);

    // Overflow: 11 distinct samples into 8 entries
    pulse_reset();
    for (int i = 1; i <= 11; i++) begin
      drive(16'(i), 1'b1, 1'b0);
      tick();
      if (i == 7) check("ovf_notfull7", 32'(bus1.full), 32'd0);
      if (i == 8) check("ovf_full8", 32'(bus1.full), 32'd1);
      if (i == 8) check("ovf_count8", 32'(bus1.count), 32'd8);
    end
    check("ovf_cnt3",  32'(bus1.overflow_cnt), 32'd3);
    check("ovf_count", 32'(bus1.count), 32'd8);
    check("ovf_head1", 32'(bus1.out_data), 32'h0001);

    // Full with simultaneous push and pop
    drive(16'h0009, 1'b1, 1'b1);
    tick();
    check("pp_count", 32'(bus1.count), 32'd8);
    check("pp_full",  32'(bus1.full), 32'd1);
    check("pp_ovf",   32'(bus1.overflow_cnt), 32'd3);
    check("pp_head",  32'(bus1.out_data), 32'h0002);
    drive(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("pp_drain", 32'(bus1.out_data), (i == 7) ? 32'h0009 : 32'(i + 2));
      tick();
    end
    check("pp_empty", 32'(bus1.out_valid), 32'd0);

    // Saturation of the drop counter
    for (int i = 0; i < 8; i++) begin
      drive(16'(16'h0040 + i), 1'b1, 1'b0);
      tick();
    end
    check("sat_fill_ovf", 32'(bus1.overflow_cnt), 32'd3);
    check("sat_fill_full", 32'(bus1.full), 32'd1);
    for (int i = 0; i < 300; i++) begin
      drive(16'(16'h0100 + i), 1'b1, 1'b0);
      tick();
      if (i == 250) check("sat_ovf254", 32'(bus1.overflow_cnt), 32'd254);
    end
    check("sat_ovf255", 32'(bus1.overflow_cnt), 32'd255);
    check("sat_count",  32'(bus1.count), 32'd8);
    check("sat_head",   32'(bus1.out_data), 32'h0040);

    // Asynchronous reset mid-cycle with 3 entries stored and 2 drops
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(16'(16'h0021 + i), 1'b1, 1'b0);
      tick();
    end
    drive(16'h0000, 1'b0, 1'b1);
    repeat (5) tick();
    check("pre_rst_count", 32'(bus1.count), 32'd3);
    check("pre_rst_ovf",   32'(bus1.overflow_cnt), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus1.out_valid), 32'd0);
    check("arst_full",  32'(bus1.full), 32'd0);
    check("arst_count", 32'(bus1.count), 32'd0);
    check("arst_ovf",   32'(bus1.overflow_cnt), 32'd0);
    #1;
    reset = 1'b0;
    // Same value as the last pre-reset sample, pushed with ready already high
    drive(16'h002A, 1'b1, 1'b1);
    tick();
    check("post_rst_count", 32'(bus1.count), 32'd1);
    check("post_rst_valid", 32'(bus1.out_valid), 32'd1);
    check("post_rst_data",  32'(bus1.out_data), 32'h002A);
    drive(16'h0000, 1'b0, 1'b1);
    tick();
    check("post_rst_pop", 32'(bus1.count), 32'd0);

    // Pointer wrap while streaming
    for (int i = 0; i < 20; i++) begin
      drive(16'(16'h0300 + i), 1'b1, 1'b1);
      tick();
      check("wrap_data",  32'(bus1.out_data), 32'(16'h0300 + i));
      check("wrap_count", 32'(bus1.count), 32'd1);
    end
    drive(16'h0000, 1'b0, 1'b1);
    tick();
    check("wrap_empty", 32'(bus1.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
